dds_chirp: RTL and testbench

// Multi-channel parallel-sample DDS with per-channel phase offset and linear-chirp (sawtooth frequency sweep) mode.

---
 rtl/dds_pkg.sv | 48 ++++
 rtl/dds_ifs.sv | 24 ++
 rtl/dds_lut.sv | 73 +++++++
 rtl/dds_chirp.sv | 141 ++++++++++++++
 tb/tb_dds_chirp.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types, constants and cosine-table builder for the chirp DDS.
// Everything here is elaboration-time only; no logic is generated.
package dds_pkg;

  localparam int PHASE_BITS       = 24;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int QUANT_BITS       = 10;
  localparam int PARALLEL_SAMPLES = 4;
  localparam int CHANNELS         = 8;
  localparam int PERIOD_BITS      = 16;
  localparam int LATENCY          = 4;

  localparam int QUARTER = 1 << (QUANT_BITS - 2);
  localparam int BEAT_W  = PARALLEL_SAMPLES * SAMPLE_WIDTH;
  localparam int CHIRP_W = PERIOD_BITS + PHASE_BITS;
  localparam int P_TRI   = PARALLEL_SAMPLES * (PARALLEL_SAMPLES - 1) / 2;
  localparam int Q_SHIFT = PHASE_BITS - QUANT_BITS;

  typedef logic [PHASE_BITS-1:0]         phase_t;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [PERIOD_BITS-1:0]        period_t;
  typedef logic [QUANT_BITS-1:0]         qphase_t;

  typedef struct packed {
    period_t period;
    phase_t  rate;
  } chirp_cfg_t;

  typedef logic [QUARTER-1:0][SAMPLE_WIDTH-1:0] rom_t;

  localparam real PI = 3.14159265358979323846;

  // First quadrant of floor(A*cos(theta) - 0.5), A = 2^(W-1) - 0.5.
  function automatic rom_t lut_init();
    rom_t r;
    real  amp;
    real  v;
    r   = '0;
    amp = (2.0 ** (SAMPLE_WIDTH - 1)) - 0.5;
    for (int i = 0; i < QUARTER; i++) begin
      v    = $floor(amp * $cos(2.0 * PI * $itor(i)
                   / $itor(1 << QUANT_BITS)) - 0.5);
      r[i] = SAMPLE_WIDTH'($rtoi(v));
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_ifs.sv
// Streaming config interface (AXI-stream subset) and the
// realtime parallel-sample output bundle used by the DDS.
interface Axis_If #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport Master (output tdata, tvalid, tlast, input tready);
  modport Slave  (input tdata, tvalid, tlast, output tready);
endinterface

interface Realtime_Parallel_If #(
  parameter int CH = 1,
  parameter int W  = 8
);
  logic [CH-1:0][W-1:0] data;
  logic [CH-1:0]        valid;

  modport Master (output data, valid);
  modport Slave  (input data, valid);
endinterface

// File: rtl/dds_lut.sv
// Quarter-wave cosine ROM with quadrant fold and sign restore.
// Ports: clk_i, rst_ni, phase_i (quantised phase), sample_o (2-cycle).
module dds_lut
  import dds_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  qphase_t phase_i,
  output sample_t sample_o
);

  localparam int   AW  = QUANT_BITS - 2;
  localparam rom_t ROM = lut_init();

  logic [1:0]    quad;
  logic [AW-1:0] idx;
  logic [AW-1:0] mir;
  logic [AW-1:0] addr_d, addr_q;
  logic          neg_d, neg_q;
  logic          zero_d, zero_q;
  sample_t       raw;
  sample_t       sample_d, sample_q;

  assign quad = phase_i[QUANT_BITS-1 -: 2];
  assign idx  = phase_i[AW-1:0];
  // Mirror index QUARTER-idx; idx==0 there means exactly cos(pi/2).
  assign mir  = ~idx + AW'(1);

  always_comb begin
    addr_d = idx;
    neg_d  = 1'b0;
    zero_d = 1'b0;
    unique case (quad)
      2'd0: addr_d = idx;
      2'd1: begin
        addr_d = mir;
        neg_d  = 1'b1;
        zero_d = (idx == '0);
      end
      2'd2: neg_d = 1'b1;
      default: begin
        addr_d = mir;
        zero_d = (idx == '0);
      end
    endcase
  end

  assign raw = ROM[addr_q];

  // cos(pi/2) quantises to floor(-0.5) = -1.
  always_comb begin
    sample_d = raw;
    if (zero_q)     sample_d = '1;
    else if (neg_q) sample_d = ~raw;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      addr_q   <= addr_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/dds_chirp.sv
// Multi-channel parallel-sample DDS with phase offset and linear chirp.
// Ports: clk, reset_n, phase_inc_in/offset_in/chirp_in (config), data_out.
module dds_chirp
  import dds_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  Axis_If.Slave               phase_inc_in,
  Axis_If.Slave               offset_in,
  Axis_If.Slave               chirp_in,
  Realtime_Parallel_If.Master data_out
);

  logic               rdy_q;
  logic [LATENCY-1:0] vld_q;
  logic               pi_we, off_we, ch_we;
  logic               resync;
  logic               unused_tlast;

  assign pi_we  = phase_inc_in.tvalid & rdy_q;
  assign off_we = offset_in.tvalid & rdy_q;
  assign ch_we  = chirp_in.tvalid & rdy_q;
  assign resync = pi_we & phase_inc_in.tlast;

  assign phase_inc_in.tready = rdy_q;
  assign offset_in.tready    = rdy_q;
  assign chirp_in.tready     = rdy_q;

  assign unused_tlast = offset_in.tlast ^ chirp_in.tlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      vld_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      vld_q <= {vld_q[LATENCY-2:0], 1'b1};
    end
  end

  assign data_out.valid = {CHANNELS{vld_q[LATENCY-1]}};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    phase_t     acc_q, acc_d;
    phase_t     base_q, base_d;
    phase_t     inc_q, inc_d;
    phase_t     rate_q, rate_d;
    phase_t     off_q, off_d;
    period_t    per_q, per_d;
    period_t    cnt_q, cnt_d;
    phase_t     rate_e;
    phase_t     pi_new;
    phase_t     off_new;
    chirp_cfg_t ch_new;
    logic       wrap;

    qphase_t [PARALLEL_SAMPLES-1:0] sq_d, sq_q;
    sample_t [PARALLEL_SAMPLES-1:0] lut_s;
    logic    [BEAT_W-1:0]           beat_q;

    assign pi_new  = phase_inc_in.tdata[c*PHASE_BITS +: PHASE_BITS];
    assign off_new = offset_in.tdata[c*PHASE_BITS +: PHASE_BITS];
    assign ch_new  = chirp_in.tdata[c*CHIRP_W +: CHIRP_W];

    // A zero period means a plain tone: the rate is ignored.
    assign rate_e = (per_q == '0) ? '0 : rate_q;
    assign wrap   = (per_q != '0) && (cnt_q == per_q - period_t'(1));

    always_comb begin
      acc_d  = acc_q + phase_t'(PARALLEL_SAMPLES) * inc_q
                     + phase_t'(P_TRI) * rate_e;
      inc_d  = wrap ? base_q
                    : inc_q + phase_t'(PARALLEL_SAMPLES) * rate_e;
      cnt_d  = wrap ? '0 : cnt_q + period_t'(1);
      base_d = base_q;
      rate_d = rate_q;
      per_d  = per_q;
      off_d  = off_q;
      if (pi_we) begin
        base_d = pi_new;
        inc_d  = pi_new;
        cnt_d  = '0;
      end
      if (resync) acc_d = '0;
      if (off_we) off_d = off_new;
      // Sweep restarts from the newest base, even one written now.
      if (ch_we) begin
        rate_d = ch_new.rate;
        per_d  = ch_new.period;
        inc_d  = pi_we ? pi_new : base_q;
        cnt_d  = '0;
      end
    end

    // Beat k: acc + off + k*inc + k(k-1)/2*rate, top bits only.
    always_comb begin
      sq_d = '0;
      for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
        sq_d[k] = qphase_t'((acc_q + off_q
                  + phase_t'(k) * inc_q
                  + phase_t'(k * (k - 1) / 2) * rate_e) >> Q_SHIFT);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q  <= '0;
        base_q <= '0;
        inc_q  <= '0;
        rate_q <= '0;
        off_q  <= '0;
        per_q  <= '0;
        cnt_q  <= '0;
        sq_q   <= '0;
        beat_q <= '0;
      end else begin
        acc_q  <= acc_d;
        base_q <= base_d;
        inc_q  <= inc_d;
        rate_q <= rate_d;
        off_q  <= off_d;
        per_q  <= per_d;
        cnt_q  <= cnt_d;
        sq_q   <= sq_d;
        beat_q <= lut_s;
      end
    end

    for (genvar k = 0; k < PARALLEL_SAMPLES; k++) begin : g_lut
      dds_lut u_lut (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .phase_i  (sq_q[k]),
        .sample_o (lut_s[k])
      );
    end

    assign data_out.data[c] = beat_q;
  end

endmodule

// File: tb/tb_dds_chirp.sv
// Randomised bench for dds_chirp against a sample-level cosine model.
// Model steps phase/increment one sample at a time using real math.
module tb_dds_chirp;
  import dds_pkg::*;

  localparam int TOL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  Axis_If #(.DATA_W(CHANNELS*PHASE_BITS)) pi_if ();
  Axis_If #(.DATA_W(CHANNELS*PHASE_BITS)) off_if ();
  Axis_If #(.DATA_W(CHANNELS*CHIRP_W))    ch_if ();
  Realtime_Parallel_If #(.CH(CHANNELS), .W(BEAT_W)) out_if ();

  dds_chirp dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .phase_inc_in (pi_if),
    .offset_in    (off_if),
    .chirp_in     (ch_if),
    .data_out     (out_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp,
                     input int tol = 0);
    int d;
    n_cmp++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state
  bit [23:0] m_acc [CHANNELS];
  bit [23:0] m_inc [CHANNELS];
  bit [23:0] m_base[CHANNELS];
  bit [23:0] m_rate[CHANNELS];
  bit [23:0] m_off [CHANNELS];
  bit [15:0] m_per [CHANNELS];
  bit [15:0] m_cnt [CHANNELS];
  int        since;
  int        hist [8][CHANNELS][PARALLEL_SAMPLES];

  // Stimulus for the next tick
  bit        s_pv, s_pl, s_ov, s_cv;
  bit [23:0] s_pi  [CHANNELS];
  bit [23:0] s_off [CHANNELS];
  bit [23:0] s_rate[CHANNELS];
  bit [15:0] s_per [CHANNELS];

  function automatic int cos_ref(input bit [23:0] ph);
    int  q;
    real v;
    q = int'(ph[23:14]);
    v = $floor(32767.5 * $cos(2.0 * 3.14159265358979323846
               * $itor(q) / 1024.0) - 0.5);
    return $rtoi(v);
  endfunction

  function automatic void model_zero();
    for (int c = 0; c < CHANNELS; c++) begin
      m_acc[c] = 0; m_inc[c] = 0; m_base[c] = 0;
      m_rate[c] = 0; m_off[c] = 0; m_per[c] = 0; m_cnt[c] = 0;
    end
  endfunction

  function automatic void snapshot();
    bit [23:0] p, i, re;
    for (int c = 0; c < CHANNELS; c++) begin
      re = (m_per[c] == 0) ? 24'd0 : m_rate[c];
      p  = m_acc[c] + m_off[c];
      i  = m_inc[c];
      for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
        hist[since % 8][c][k] = cos_ref(p);
        p = p + i;
        i = i + re;
      end
    end
  endfunction

  function automatic void model_advance();
    bit [23:0] a, i, re;
    for (int c = 0; c < CHANNELS; c++) begin
      re = (m_per[c] == 0) ? 24'd0 : m_rate[c];
      a  = m_acc[c];
      i  = m_inc[c];
      for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
        a = a + i;
        i = i + re;
      end
      m_acc[c] = a;
      if (m_per[c] != 0 && m_cnt[c] == m_per[c] - 16'd1) begin
        m_inc[c] = m_base[c];
        m_cnt[c] = 0;
      end else begin
        m_inc[c] = i;
        m_cnt[c] = m_cnt[c] + 16'd1;
      end
    end
    if (since < 1) return;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s_pv) begin
        m_base[c] = s_pi[c];
        m_inc[c]  = s_pi[c];
        m_cnt[c]  = 0;
        if (s_pl) m_acc[c] = 0;
      end
      if (s_ov) m_off[c] = s_off[c];
      if (s_cv) begin
        m_rate[c] = s_rate[c];
        m_per[c]  = s_per[c];
        m_inc[c]  = m_base[c];
        m_cnt[c]  = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    sample_t s;
    chk("pi_tready", int'(pi_if.tready), int'(since >= 1));
    chk("off_tready", int'(off_if.tready), int'(since >= 1));
    chk("ch_tready", int'(ch_if.tready), int'(since >= 1));
    for (int c = 0; c < CHANNELS; c++) begin
      chk($sformatf("valid%0d", c), int'(out_if.valid[c]),
          int'(since >= LATENCY));
      if (since >= LATENCY) begin
        for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
          s = out_if.data[c][k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          chk($sformatf("ch%0d_s%0d_cyc%0d", c, k, since), int'(s),
              hist[(since - LATENCY) % 8][c][k], TOL);
        end
      end
    end
  endtask

  task automatic tick();
    pi_if.tvalid  = s_pv;
    pi_if.tlast   = s_pl;
    off_if.tvalid = s_ov;
    ch_if.tvalid  = s_cv;
    for (int c = 0; c < CHANNELS; c++) begin
      pi_if.tdata[c*PHASE_BITS +: PHASE_BITS] = s_pi[c];
      off_if.tdata[c*PHASE_BITS +: PHASE_BITS] = s_off[c];
      ch_if.tdata[c*CHIRP_W +: CHIRP_W] = {s_per[c], s_rate[c]};
    end
    model_advance();
    @(posedge clk);
    since++;
    @(negedge clk);
    check_outputs();
    snapshot();
    s_pv = 0; s_pl = 0; s_ov = 0; s_cv = 0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic in_reset_checks(input string tag);
    chk({tag, "_tready"}, int'(pi_if.tready | off_if.tready
        | ch_if.tready), 0);
    for (int c = 0; c < CHANNELS; c++) begin
      chk($sformatf("%s_valid%0d", tag, c), int'(out_if.valid[c]), 0);
      chk($sformatf("%s_data%0d", tag, c), int'(|out_if.data[c]), 0);
    end
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    model_zero();
    since = 0;
    snapshot();
  endtask

  task automatic rand_stim();
    s_pv = ($urandom % 6) == 0;
    s_pl = ($urandom % 3) == 0;
    s_ov = ($urandom % 8) == 0;
    s_cv = ($urandom % 8) == 0;
    for (int c = 0; c < CHANNELS; c++) begin
      s_pi[c]   = 24'($urandom);
      s_off[c]  = 24'($urandom);
      s_rate[c] = 24'($urandom % 4096);
      s_per[c]  = (($urandom % 3) == 0) ? 16'd0
                  : 16'($urandom_range(1, 40));
    end
  endtask

  initial begin
    pi_if.tvalid = 0; pi_if.tlast = 0; pi_if.tdata = '0;
    off_if.tvalid = 0; off_if.tlast = 0; off_if.tdata = '0;
    ch_if.tvalid = 0; ch_if.tlast = 0; ch_if.tdata = '0;
    s_pv = 0; s_pl = 0; s_ov = 0; s_cv = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      s_pi[c] = 0; s_off[c] = 0; s_rate[c] = 0; s_per[c] = 0;
    end

    // Reset held, then idle output must be full-scale cosine of 0.
    repeat (3) @(negedge clk);
    in_reset_checks("por");
    release_reset();
    run(4);
    for (int c = 0; c < CHANNELS; c++)
      chk($sformatf("idle_beat%0d", c),
          int'(out_if.data[c] == {4{16'h7fff}}), 1);
    run(4);

    // Plain tone with resync
    s_pv = 1; s_pl = 1;
    for (int c = 0; c < CHANNELS; c++) s_pi[c] = 24'h040000;
    run(40);

    // Retune without resync: phase must stay continuous
    s_pv = 1;
    for (int c = 0; c < CHANNELS; c++) s_pi[c] = 24'h080000;
    run(20);

    // Half-cycle offset on channel 1
    s_pv = 1; s_pl = 1; s_ov = 1;
    for (int c = 0; c < CHANNELS; c++) begin
      s_pi[c]  = 24'h040000;
      s_off[c] = (c == 1) ? 24'h800000 : 24'h0;
    end
    run(24);

    // Chirp from zero, rate 1, period 16, then freeze
    s_pv = 1; s_pl = 1; s_ov = 1; s_cv = 1;
    for (int c = 0; c < CHANNELS; c++) begin
      s_pi[c] = 0; s_off[c] = 0; s_rate[c] = 24'd1; s_per[c] = 16'd16;
    end
    run(60);
    s_cv = 1;
    for (int c = 0; c < CHANNELS; c++) s_per[c] = 16'd0;
    run(20);

    // Fast chirp to exercise the quadratic term
    s_cv = 1;
    for (int c = 0; c < CHANNELS; c++) begin
      s_rate[c] = 24'h000400 * (c + 1); s_per[c] = 16'(5 + c);
    end
    run(40);

    // Different increments, then resync to a common one
    s_pv = 1; s_cv = 1;
    for (int c = 0; c < CHANNELS; c++) begin
      s_pi[c] = 24'($urandom); s_per[c] = 0; s_rate[c] = 0;
    end
    run(10);
    s_pv = 1; s_pl = 1;
    for (int c = 0; c < CHANNELS; c++) s_pi[c] = 24'h123456;
    run(20);

    // Random configuration traffic
    repeat (400) begin
      rand_stim();
      tick();
    end

    // Asynchronous reset mid-stream
    #2 reset_n = 1'b0;
    #1 in_reset_checks("mid");
    @(negedge clk);
    @(negedge clk);
    in_reset_checks("mid_hold");
    release_reset();
    run(4);
    for (int c = 0; c < CHANNELS; c++)
      chk($sformatf("recov_beat%0d", c),
          int'(out_if.data[c] == {4{16'h7fff}}), 1);
    run(4);
    repeat (100) begin
      rand_stim();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
